// File: rtl/psdsqrt_hs.sv
// Sequential restoring square-root unit: one result bit per clock, start/busy/done
// handshake with abort, optional round-to-nearest with saturation, and remainder output.
module psdsqrt_hs #(
    parameter int NBITSIN  = 32,
    parameter int FRACBITS = 0,
    localparam int W = NBITSIN / 2 + FRACBITS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               round_en,
    input  logic               abort,
    input  logic [NBITSIN-1:0] xin,
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       sqrt,
    output logic [W:0]         rem,
    output logic               sat
);

    localparam int XW = 2 * W;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;

    state_t          state, state_n;
    logic [XW-1:0]   x_sh;
    logic [W-1:0]    q;
    logic [W:0]      pr;
    logic [CW-1:0]   cnt;
    logic            round_q;

    logic [W+1:0]    rem_sh;
    logic [W+1:0]    trial;
    logic [W+1:0]    diff;
    logic            fits;
    logic            last;
    logic            round_up;

    // Bring down the next radicand digit pair and try setting the next root bit.
    assign rem_sh   = {pr[W-1:0], x_sh[XW-1 -: 2]};
    assign trial    = {q, 2'b01};
    assign diff     = rem_sh - trial;
    assign fits     = (rem_sh >= trial);
    assign last     = (cnt == CW'(W - 1));
    assign round_up = round_q && (pr > {1'b0, q});

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // NOTE: state_n gets a default before the case so no path infers a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = CALC;
            CALC:  if (abort) state_n = IDLE;
                   else if (last) state_n = ROUND;
            ROUND: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sqrt    <= '0;
            rem     <= '0;
            sat     <= 1'b0;
            x_sh    <= '0;
            q       <= '0;
            pr      <= '0;
            cnt     <= '0;
            round_q <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_sh    <= XW'(xin) << (2 * FRACBITS);
                        q       <= '0;
                        pr      <= '0;
                        cnt     <= '0;
                        round_q <= round_en;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        x_sh <= x_sh << 2;
                        q    <= {q[W-2:0], fits};
                        pr   <= fits ? diff[W:0] : rem_sh[W:0];
                        cnt  <= cnt + 1'b1;
                    end
                end
                ROUND: begin
                    busy <= 1'b0;
                    if (!abort) begin
                        done <= 1'b1;
                        rem  <= pr;
                        // Rounding up an all-ones root cannot be represented, so clamp.
                        if (round_up && (&q)) begin
                            sqrt <= '1;
                            sat  <= 1'b1;
                        end else if (round_up) begin
                            sqrt <= q + 1'b1;
                            sat  <= 1'b0;
                        end else begin
                            sqrt <= q;
                            sat  <= 1'b0;
                        end
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/psdsqrt_hs.md
Name: psdsqrt_hs

Overview:
- Next-generation sequential square-root unit. One result bit per clock, restoring digit-by-digit algorithm.
- Generalised input width and fractional-result precision.
- Adds a start/busy/done handshake, abort, optional round-to-nearest with saturation, and a remainder output.
- Sits as a standalone arithmetic core driven by a controller or bench. Replaces the fixed-timing start/stop sequence of the previous generation.

Parameters:
- NBITSIN, 32: integer radicand width in bits. Must be even and >= 4.
- FRACBITS, 0: fractional bits in the result. The radicand is internally extended by 2*FRACBITS zero LSBs.
- W (localparam), NBITSIN/2+FRACBITS: result width, and the number of iteration cycles.

Ports:
- clock, in, 1: master clock, active on the positive edge.
- reset, in, 1: master reset, synchronous, active low (0 = reset).
- start, in, 1: request a new operation. Sampled only in IDLE.
- round_en, in, 1: rounding mode, latched when start is accepted. 1 = round-to-nearest, 0 = truncate.
- abort, in, 1: cancel the operation in progress.
- xin, in, NBITSIN: radicand (unsigned integer), latched when start is accepted.
- busy, out, 1: high while an operation is in progress.
- done, out, 1: one-cycle pulse when new results are loaded.
- sqrt, out, W: result. Unsigned fixed point, FRACBITS fraction bits.
- rem, out, W+1: truncated remainder, xin*4^FRACBITS - q^2, where q is the truncated root.
- sat, out, 1: set when rounding would overflow W bits.

Behaviour:
- Reset (reset==0 at a posedge): state goes to IDLE. busy, done, sqrt, rem, sat are all 0. Reset overrides every other input, including mid-operation; any partial result is discarded.
- States: IDLE, CALC, ROUND.
- IDLE:
  - start==1 latches xin and round_en, clears the iteration counter, then goes to CALC. busy=1 from the same edge.
  - start==0: stays in IDLE.
- CALC: one iteration per cycle, from bit W-1 down to bit 0.
  - Trial bit set in q. If extended radicand >= trial^2, keep the bit; otherwise clear it. Equivalent shift/subtract datapath on the partial remainder is acceptable.
  - After exactly W CALC cycles, go to ROUND.
- ROUND: single cycle, at the edge leaving ROUND.
  - rem <= truncated remainder.
  - If round_en==1 and remainder > q: round up (condition exactly equivalent to radicand >= (q+0.5)^2).
    - If q is all ones: sqrt <= all ones, sat <= 1.
    - Otherwise: sqrt <= q+1, sat <= 0.
  - Else: sqrt <= q, sat <= 0.
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: start accepted at edge E0 gives done high and results valid after edge E0+W+1. Latency is fixed and independent of data and round_en.
- Back-to-back operation: a start sampled in the cycle where done is high is accepted, so throughput is one result per W+2 cycles.
- start while busy: ignored, with no effect on the current operation.
- abort==1 in CALC or ROUND: next state IDLE, busy <= 0, no done pulse; sqrt/rem/sat keep their previous values. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Outputs sqrt/rem/sat hold their values between completions and change only at a ROUND exit or at reset.
- Widths:
  - Extended radicand: NBITSIN+2*FRACBITS bits.
  - Partial-remainder datapath: at least W+2 bits, with no truncation.
  - rem never exceeds 2q, so W+1 bits suffice.

Test Plan:
- NBITSIN=32, FRACBITS=0, round_en=0, xin=123456 -> sqrt=351, rem=255, sat=0. done high exactly 17 cycles after the start edge; busy high for those 17 cycles.
- Same configuration with round_en=1: xin=123456 -> 351 (255 is not > 351). xin=0 -> sqrt=0, rem=0. xin=0xFFFFFFFF -> truncated 65535 with rem=131070; rounding overflows, so sqrt=65535, sat=1.
- NBITSIN=32, FRACBITS=4 (W=20), xin=2: round_en=0 -> sqrt=22 (1.375), rem=28. round_en=1 -> sqrt=23. done 21 cycles after start.
- Handshake: pulse start again 5 cycles into an operation with a different xin -> ignored, first result unchanged. start held high during the done cycle -> second operation accepted, and its done arrives W+2 cycles after the first done.
- abort asserted at CALC cycle 8 -> busy falls next edge, no done, previous sqrt/rem retained. A following start completes correctly.
- reset=0 mid-CALC -> all outputs 0 at the next edge, state IDLE. A random sweep of xin in 0..100000 (FRACBITS=0, round_en=0) must match the integer floor square root, with rem = xin - sqrt^2.
